// File: rtl/vga_bounce_box.sv
// vga_bounce_box: pixel stage behind a 640x480 VGA timing generator.
// It draws a solid square on a flat background. The square bounces off the
// screen edges and moves once per frame, during blanking. The RGB444 output
// is registered, and hs/vs are delayed by the same single strobe so they stay
// aligned with the colour.
// Optional feature: define VGA_BOUNCE_FLASH_EN to make the box colour cycle
// red -> green -> blue -> yellow on every bounce update.
module vga_bounce_box #(
  parameter int unsigned H_RES     = 640,
  parameter int unsigned V_RES     = 480,
  parameter int unsigned BOX_SIZE  = 32,
  parameter int unsigned STEP      = 2,
  parameter int unsigned X_INIT    = 0,
  parameter int unsigned Y_INIT    = 0,
  parameter logic [11:0] BG_COLOR  = 12'h000,
  parameter logic [11:0] BOX_COLOR = 12'hF00
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pix_stb,
  input  logic       i_hs,
  input  logic       i_vs,
  input  logic       i_active,
  input  logic       i_animate,
  input  logic [9:0] i_x,
  input  logic [8:0] i_y,
  output logic       o_hs,
  output logic       o_vs,
  output logic [3:0] o_r,
  output logic [3:0] o_g,
  output logic [3:0] o_b,
  output logic       o_bounce
);

  // All compare and step arithmetic is 11 bits wide, so box + size cannot wrap.
  localparam logic [10:0] BOX_W  = 11'(BOX_SIZE);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] X_LIM  = 11'(H_RES - BOX_SIZE);
  localparam logic [10:0] Y_LIM  = 11'(V_RES - BOX_SIZE);
  localparam logic [9:0]  X_RST  = 10'(X_INIT);
  localparam logic [8:0]  Y_RST  = 9'(Y_INIT);

  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic [11:0] rgb_q, rgb_d;
  logic        bounce_q, bounce_d;
  logic [9:0]  box_x_q, box_x_d;
  logic [8:0]  box_y_q, box_y_d;
  logic        dir_x_q, dir_x_d;  // 1 = moving toward +x, 0 = toward -x
  logic        dir_y_q, dir_y_d;  // 1 = moving toward +y, 0 = toward -y

  logic [10:0] x_ext, y_ext, bx_ext, by_ext, nx, ny;
  logic        hit, upd, flip_x, flip_y;
  logic [11:0] box_color;

  assign x_ext  = {1'b0, i_x};
  assign y_ext  = {2'b00, i_y};
  assign bx_ext = {1'b0, box_x_q};
  assign by_ext = {2'b00, box_y_q};
  assign nx     = bx_ext + STEP_W;
  assign ny     = by_ext + STEP_W;
  assign upd    = i_animate & i_pix_stb;

`ifdef VGA_BOUNCE_FLASH_EN
  logic [1:0] idx_q, idx_d;

  // Box colour chosen from the bounce-advanced palette index.
  always_comb begin
    unique case (idx_q)
      2'd0:    box_color = 12'hF00;
      2'd1:    box_color = 12'h0F0;
      2'd2:    box_color = 12'h00F;
      default: box_color = 12'hFF0;
    endcase
  end

  // Palette index steps once per bounce update; a corner bounce counts once.
  always_comb begin
    idx_d = idx_q;
    if (bounce_d) idx_d = idx_q + 2'd1;
  end

  // Palette index register.
  always_ff @(posedge i_clk) begin
    if (i_rst) idx_q <= 2'd0;
    else       idx_q <= idx_d;
  end
`else
  assign box_color = BOX_COLOR;
`endif

  // Pixel path: sample sync and colour on each strobe, hold otherwise.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    hs_d  = hs_q;
    vs_d  = vs_q;
    rgb_d = rgb_q;
    hit   = i_active &&
            (x_ext >= bx_ext) && (x_ext < bx_ext + BOX_W) &&
            (y_ext >= by_ext) && (y_ext < by_ext + BOX_W);
    if (i_pix_stb) begin
      hs_d  = i_hs;
      vs_d  = i_vs;
      rgb_d = hit ? box_color : (i_active ? BG_COLOR : 12'h000);
    end
  end

  // Motion: one step per frame on the animate tick, clamped at the walls.
  always_comb begin
    box_x_d = box_x_q;
    box_y_d = box_y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    flip_x  = 1'b0;
    flip_y  = 1'b0;
    if (upd) begin
      if (dir_x_q) begin
        if (nx >= X_LIM) begin
          box_x_d = X_LIM[9:0];
          dir_x_d = 1'b0;
          flip_x  = 1'b1;
        end else begin
          box_x_d = nx[9:0];
        end
      end else begin
        if (bx_ext <= STEP_W) begin
          box_x_d = '0;
          dir_x_d = 1'b1;
          flip_x  = 1'b1;
        end else begin
          box_x_d = box_x_q - STEP_W[9:0];
        end
      end
      if (dir_y_q) begin
        if (ny >= Y_LIM) begin
          box_y_d = Y_LIM[8:0];
          dir_y_d = 1'b0;
          flip_y  = 1'b1;
        end else begin
          box_y_d = ny[8:0];
        end
      end else begin
        if (by_ext <= STEP_W) begin
          box_y_d = '0;
          dir_y_d = 1'b1;
          flip_y  = 1'b1;
        end else begin
          box_y_d = box_y_q - STEP_W[8:0];
        end
      end
    end
    // Single-clock pulse; a corner bounce still gives only one pulse.
    bounce_d = flip_x | flip_y;
  end

  // State registers with synchronous reset; reset wins over a same-cycle strobe.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples the pre-edge values, independent of statement order.
    if (i_rst) begin
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      rgb_q    <= 12'h000;
      bounce_q <= 1'b0;
      box_x_q  <= X_RST;
      box_y_q  <= Y_RST;
      dir_x_q  <= 1'b1;
      dir_y_q  <= 1'b1;
    end else begin
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      rgb_q    <= rgb_d;
      bounce_q <= bounce_d;
      box_x_q  <= box_x_d;
      box_y_q  <= box_y_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
    end
  end

  assign o_hs     = hs_q;
  assign o_vs     = vs_q;
  assign o_r      = rgb_q[11:8];
  assign o_g      = rgb_q[7:4];
  assign o_b      = rgb_q[3:0];
  assign o_bounce = bounce_q;

endmodule

// File: tb/tb_vga_bounce_box.sv
// Directed bench for vga_bounce_box. Four instances with different start
// positions share one stimulus stream. Expected values are queued when a step
// is driven, then popped and compared half a clock after the active edge.
module tb_vga_bounce_box;

  logic       clk = 1'b0;
  logic       rst, stb, hs, vs, act, anim;
  logic [9:0] x;
  logic [8:0] y;

  logic [3:0] r [4];
  logic [3:0] g [4];
  logic [3:0] b [4];
  logic       ohs [4];
  logic       ovs [4];
  logic       bnc [4];

  always #5 clk = ~clk;

  vga_bounce_box d0 (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .i_hs(hs), .i_vs(vs),
    .i_active(act), .i_animate(anim), .i_x(x), .i_y(y),
    .o_hs(ohs[0]), .o_vs(ovs[0]), .o_r(r[0]), .o_g(g[0]), .o_b(b[0]), .o_bounce(bnc[0]));

  vga_bounce_box #(.X_INIT(606), .Y_INIT(100)) d1 (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .i_hs(hs), .i_vs(vs),
    .i_active(act), .i_animate(anim), .i_x(x), .i_y(y),
    .o_hs(ohs[1]), .o_vs(ovs[1]), .o_r(r[1]), .o_g(g[1]), .o_b(b[1]), .o_bounce(bnc[1]));

  // Narrow screen: right wall at x=8, so the left-wall bounce is reached quickly.
  vga_bounce_box #(.H_RES(40), .X_INIT(6), .Y_INIT(0)) d2 (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .i_hs(hs), .i_vs(vs),
    .i_active(act), .i_animate(anim), .i_x(x), .i_y(y),
    .o_hs(ohs[2]), .o_vs(ovs[2]), .o_r(r[2]), .o_g(g[2]), .o_b(b[2]), .o_bounce(bnc[2]));

  vga_bounce_box #(.X_INIT(606), .Y_INIT(446)) d3 (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .i_hs(hs), .i_vs(vs),
    .i_active(act), .i_animate(anim), .i_x(x), .i_y(y),
    .o_hs(ohs[3]), .o_vs(ovs[3]), .o_r(r[3]), .o_g(g[3]), .o_b(b[3]), .o_bounce(bnc[3]));

  typedef enum int {
    O0_RGB, O0_HS, O0_VS, O0_BNC, O0_BX, O0_BY, O0_DX, O0_DY,
    O1_RGB, O1_BX, O1_BY, O1_DX, O1_BNC,
    O2_BX, O2_BY, O2_DX, O2_BNC,
    O3_RGB, O3_BX, O3_BY, O3_DX, O3_DY, O3_BNC
  } obs_e;

  typedef struct {
    obs_e        sel;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic logic [31:0] observe(input obs_e s);
    case (s)
      O0_RGB:  return 32'({r[0], g[0], b[0]});
      O0_HS:   return 32'(ohs[0]);
      O0_VS:   return 32'(ovs[0]);
      O0_BNC:  return 32'(bnc[0]);
      O0_BX:   return 32'(d0.box_x_q);
      O0_BY:   return 32'(d0.box_y_q);
      O0_DX:   return 32'(d0.dir_x_q);
      O0_DY:   return 32'(d0.dir_y_q);
      O1_RGB:  return 32'({r[1], g[1], b[1]});
      O1_BX:   return 32'(d1.box_x_q);
      O1_BY:   return 32'(d1.box_y_q);
      O1_DX:   return 32'(d1.dir_x_q);
      O1_BNC:  return 32'(bnc[1]);
      O2_BX:   return 32'(d2.box_x_q);
      O2_BY:   return 32'(d2.box_y_q);
      O2_DX:   return 32'(d2.dir_x_q);
      O2_BNC:  return 32'(bnc[2]);
      O3_RGB:  return 32'({r[3], g[3], b[3]});
      O3_BX:   return 32'(d3.box_x_q);
      O3_BY:   return 32'(d3.box_y_q);
      O3_DX:   return 32'(d3.dir_x_q);
      O3_DY:   return 32'(d3.dir_y_q);
      O3_BNC:  return 32'(bnc[3]);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_v(input obs_e s, input logic [31:0] e, input string t);
    exp_t ent;
    ent.sel = s;
    ent.exp = e;
    ent.tag = t;
    sb.push_back(ent);
  endtask

  task automatic check(input exp_t ent);
    logic [31:0] got;
    got = observe(ent.sel);
    vectors++;
    assert (got === ent.exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", ent.tag, got, ent.exp);
    end
  endtask

  task automatic drive(input logic s, input logic an, input logic ac,
                       input logic h, input logic v,
                       input logic [9:0] px, input logic [8:0] py);
    stb = s; anim = an; act = ac; hs = h; vs = v; x = px; y = py;
  endtask

  // One active edge, then compare every queued expectation on the falling edge.
  task automatic tick();
    exp_t ent;
    @(posedge clk);
    @(negedge clk);
    while (sb.size() > 0) begin
      ent = sb.pop_front();
      check(ent);
    end
  endtask

  localparam logic [11:0] FLASH1 =
`ifdef VGA_BOUNCE_FLASH_EN
    12'h0F0;
`else
    12'hF00;
`endif

  initial begin
    rst = 1'b1;
    drive(1, 0, 1, 0, 0, 10'd0, 9'd0);  // strobe during reset is ignored
    expect_v(O0_RGB, 12'h000, "rst_rgb");
    expect_v(O0_HS, 1, "rst_hs");
    expect_v(O0_VS, 1, "rst_vs");
    expect_v(O0_BNC, 0, "rst_bounce");
    expect_v(O0_BX, 0, "rst_box_x");
    expect_v(O0_BY, 0, "rst_box_y");
    expect_v(O1_BX, 606, "rst_d1_box_x");
    expect_v(O1_DX, 1, "rst_d1_dir_x");
    tick();
    rst = 1'b0;

    // Pixel path: 1 strobe latency, box hit and its edges.
    drive(1, 0, 1, 0, 1, 10'd0, 9'd0);
    expect_v(O0_RGB, 12'hF00, "pix_origin");
    expect_v(O0_HS, 0, "pix_hs");
    expect_v(O0_VS, 1, "pix_vs");
    expect_v(O1_RGB, 12'h000, "pix_d1_bg");
    tick();
    drive(1, 0, 1, 1, 0, 10'd32, 9'd0);
    expect_v(O0_RGB, 12'h000, "pix_x32_bg");
    expect_v(O0_HS, 1, "pix_hs2");
    expect_v(O0_VS, 0, "pix_vs2");
    tick();
    drive(1, 0, 1, 1, 1, 10'd31, 9'd31);
    expect_v(O0_RGB, 12'hF00, "pix_31_31");
    tick();
    drive(1, 0, 1, 1, 1, 10'd31, 9'd32);
    expect_v(O0_RGB, 12'h000, "pix_y32_bg");
    tick();
    drive(1, 0, 0, 1, 1, 10'd0, 9'd0);
    expect_v(O0_RGB, 12'h000, "pix_inactive");
    tick();
    drive(0, 0, 1, 0, 0, 10'd0, 9'd0);  // no strobe: outputs hold
    expect_v(O0_RGB, 12'h000, "hold_rgb");
    expect_v(O0_HS, 1, "hold_hs");
    tick();

    // Animate 1: right-wall bounce (d1, d2), corner bounce (d3), plain move (d0).
    drive(1, 1, 0, 1, 1, 10'd0, 9'd0);
    expect_v(O0_BX, 2, "a1_d0_x");
    expect_v(O0_BY, 2, "a1_d0_y");
    expect_v(O0_BNC, 0, "a1_d0_bounce");
    expect_v(O1_BX, 608, "a1_d1_x");
    expect_v(O1_BY, 102, "a1_d1_y");
    expect_v(O1_DX, 0, "a1_d1_dir_x");
    expect_v(O1_BNC, 1, "a1_d1_bounce");
    expect_v(O2_BX, 8, "a1_d2_x");
    expect_v(O2_BNC, 1, "a1_d2_bounce");
    expect_v(O3_BX, 608, "a1_d3_x");
    expect_v(O3_BY, 448, "a1_d3_y");
    expect_v(O3_DX, 0, "a1_d3_dir_x");
    expect_v(O3_DY, 0, "a1_d3_dir_y");
    expect_v(O3_BNC, 1, "a1_d3_bounce");
    tick();
    drive(0, 0, 0, 1, 1, 10'd0, 9'd0);
    expect_v(O1_BNC, 0, "a1_d1_pulse_end");
    expect_v(O3_BNC, 0, "a1_d3_pulse_end");
    expect_v(O1_BX, 608, "a1_d1_x_hold");
    tick();

    // Clamped corner box is drawn fully on screen, in its advanced colour.
    drive(1, 0, 1, 1, 1, 10'd608, 9'd448);
    expect_v(O3_RGB, FLASH1, "d3_corner_tl");
    tick();
    drive(1, 0, 1, 1, 1, 10'd639, 9'd479);
    expect_v(O3_RGB, FLASH1, "d3_corner_br");
    tick();
    drive(1, 0, 1, 1, 1, 10'd607, 9'd479);
    expect_v(O3_RGB, 12'h000, "d3_left_of_box");
    tick();

    // Animate 2: moving back from the walls.
    drive(1, 1, 0, 1, 1, 10'd0, 9'd0);
    expect_v(O1_BX, 606, "a2_d1_x");
    expect_v(O1_BY, 104, "a2_d1_y");
    expect_v(O1_BNC, 0, "a2_d1_bounce");
    expect_v(O2_BX, 6, "a2_d2_x");
    expect_v(O3_BX, 606, "a2_d3_x");
    expect_v(O3_BY, 446, "a2_d3_y");
    tick();
    drive(0, 0, 0, 1, 1, 10'd0, 9'd0);
    tick();

    // Animates 3 and 4 walk d2 down to x=2 heading left.
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 1, 1, 10'd0, 9'd0);
      expect_v(O2_BNC, 0, "a34_d2_bounce");
      tick();
      drive(0, 0, 0, 1, 1, 10'd0, 9'd0);
      tick();
    end
    drive(1, 1, 0, 1, 1, 10'd0, 9'd0);  // animate 5: left-wall bounce for d2
    expect_v(O2_BX, 0, "a5_d2_x");
    expect_v(O2_DX, 1, "a5_d2_dir_x");
    expect_v(O2_BY, 10, "a5_d2_y");
    expect_v(O2_BNC, 1, "a5_d2_bounce");
    expect_v(O0_BX, 10, "a5_d0_x");
    tick();
    drive(0, 0, 0, 1, 1, 10'd0, 9'd0);
    expect_v(O2_BNC, 0, "a5_d2_pulse_end");
    tick();

    // i_animate held 5 clks with a single strobe: exactly one update.
    for (int i = 0; i < 5; i++) begin
      drive((i == 2), 1, 0, 1, 1, 10'd0, 9'd0);
      tick();
    end
    drive(0, 0, 0, 1, 1, 10'd0, 9'd0);
    expect_v(O0_BX, 12, "hold_anim_d0_x");
    expect_v(O0_BY, 12, "hold_anim_d0_y");
    expect_v(O1_BX, 598, "hold_anim_d1_x");
    expect_v(O1_BY, 112, "hold_anim_d1_y");
    expect_v(O2_BX, 2, "hold_anim_d2_x");
    tick();

    // Reset mid-line while strobing.
    drive(1, 0, 1, 0, 0, 10'd20, 9'd20);
    tick();
    rst = 1'b1;
    drive(1, 0, 1, 0, 0, 10'd21, 9'd20);
    expect_v(O0_RGB, 12'h000, "mid_rst_rgb");
    expect_v(O0_HS, 1, "mid_rst_hs");
    expect_v(O0_VS, 1, "mid_rst_vs");
    expect_v(O0_BX, 0, "mid_rst_d0_x");
    expect_v(O0_BY, 0, "mid_rst_d0_y");
    expect_v(O0_DX, 1, "mid_rst_d0_dir_x");
    expect_v(O0_DY, 1, "mid_rst_d0_dir_y");
    expect_v(O1_BX, 606, "mid_rst_d1_x");
    expect_v(O1_BY, 100, "mid_rst_d1_y");
    expect_v(O1_DX, 1, "mid_rst_d1_dir_x");
    expect_v(O3_DY, 1, "mid_rst_d3_dir_y");
    tick();
    rst = 1'b0;
    drive(1, 0, 1, 0, 0, 10'd0, 9'd0);
    expect_v(O0_RGB, 12'hF00, "post_rst_rgb");
    expect_v(O0_HS, 0, "post_rst_hs");
    expect_v(O0_VS, 0, "post_rst_vs");
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
